// File: rtl/mbe_pkg.sv
// ----------------------------------------------------------------------------
// mbe_pkg
// Shared types and constants for the radix-4 Booth partial-product
// accumulator: FSM state encoding, the per-digit Booth bundle, default
// operand sizes and the product-width derivation.
// ----------------------------------------------------------------------------
package mbe_pkg;

    localparam int MBE_W_DEFAULT = 8;   // multiplicand width
    localparam int MBE_N_DEFAULT = 4;   // Booth digits (multiplier = 2N bits)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mbe_state_e;

    // One Booth digit as emitted by the encoder.
    typedef struct packed {
        logic single;
        logic double;
        logic neg;
    } mbe_digit_t;

    // Product width: multiplicand width plus multiplier width.
    function automatic int mbe_p(input int w, input int n);
        return w + 2 * n;
    endfunction

endpackage

// File: rtl/mbe_pp_sel.sv
// ----------------------------------------------------------------------------
// mbe_pp_sel
// Combinational single-digit Booth selector. Produces the (W+2)-bit
// sign-corrected partial product for one digit.
// Optional feature macro: MBE_PP_CHECK_EN (illegal single&double digit is
// forced to magnitude 0 and flagged on illegal_o).
// Ports:
//   y_i       : signed multiplicand
//   dig_i     : Booth digit bundle {single, double, neg}
//   pp_o      : sign-corrected partial product, W+2 bits
//   illegal_o : digit has single&double set (MBE_PP_CHECK_EN only)
// ----------------------------------------------------------------------------
module mbe_pp_sel
    import mbe_pkg::*;
#(
    parameter int W = MBE_W_DEFAULT
) (
    input  logic [W-1:0] y_i,
    input  mbe_digit_t   dig_i,
    output logic [W+1:0] pp_o
`ifdef MBE_PP_CHECK_EN
    ,
    output logic         illegal_o
`endif
);

    logic [W+1:0] y_ext;
    logic [W+1:0] mag;

    assign y_ext = {{2{y_i[W-1]}}, y_i};

`ifdef MBE_PP_CHECK_EN
    assign illegal_o = dig_i.single & dig_i.double;
`endif

    always_comb begin
        mag = '0;
`ifdef MBE_PP_CHECK_EN
        if (dig_i.single & dig_i.double) begin
            mag = '0;
        end else if (dig_i.single) begin
            mag = y_ext;
        end else if (dig_i.double) begin
            mag = y_ext << 1;
        end
`else
        if (dig_i.single) begin
            mag = y_ext;
        end else if (dig_i.double) begin
            mag = y_ext << 1;
        end
`endif
        // Negating a zero magnitude yields ~0+1 = 0, so a "negative zero"
        // digit contributes nothing rather than -1.
        pp_o = (mag ^ {(W+2){dig_i.neg}}) + {{(W+1){1'b0}}, dig_i.neg};
    end

endmodule

// File: rtl/mbe_pp_accum.sv
// ----------------------------------------------------------------------------
// mbe_pp_accum
// Sequential radix-4 Booth partial-product selector and accumulator. One
// digit is selected, shifted to weight 4^k and added to the product
// register per cycle; valid/ready handshakes on input and output.
// Optional feature macro: MBE_PP_CHECK_EN (adds sticky err output).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake
//   y                   : signed multiplicand
//   single/double/neg   : per-digit Booth bundle (N bits each)
//   out_valid/out_ready : result handshake
//   product             : signed product, P = W+2N bits
//   err                 : sticky illegal-digit flag (MBE_PP_CHECK_EN only)
// ----------------------------------------------------------------------------
module mbe_pp_accum
    import mbe_pkg::*;
#(
    parameter int W = MBE_W_DEFAULT,
    parameter int N = MBE_N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           y,
    input  logic [N-1:0]           single,
    input  logic [N-1:0]           double,
    input  logic [N-1:0]           neg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [mbe_p(W,N)-1:0]  product
`ifdef MBE_PP_CHECK_EN
    ,
    output logic                   err
`endif
);

    localparam int P  = mbe_p(W, N);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mbe_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [P-1:0]   acc_q, acc_d;
    logic [W-1:0]   y_q, y_d;
    logic [N-1:0]   sgl_q, sgl_d;
    logic [N-1:0]   dbl_q, dbl_d;
    logic [N-1:0]   neg_q, neg_d;

    mbe_digit_t     dig;
    logic [W+1:0]   pp;
    logic [P-1:0]   pp_ext;
    logic           accept;

    assign dig = '{single: sgl_q[cnt_q], double: dbl_q[cnt_q], neg: neg_q[cnt_q]};

`ifdef MBE_PP_CHECK_EN
    logic illegal;
    logic err_q, err_d;

    mbe_pp_sel #(.W(W)) u_sel (
        .y_i       (y_q),
        .dig_i     (dig),
        .pp_o      (pp),
        .illegal_o (illegal)
    );

    assign err = err_q;
`else
    mbe_pp_sel #(.W(W)) u_sel (
        .y_i  (y_q),
        .dig_i(dig),
        .pp_o (pp)
    );
`endif

    assign pp_ext    = {{(P-W-2){pp[W+1]}}, pp};
    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign product   = acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        y_d     = y_q;
        sgl_d   = sgl_q;
        dbl_d   = dbl_q;
        neg_d   = neg_q;
`ifdef MBE_PP_CHECK_EN
        err_d   = err_q;
`endif

        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                acc_d = acc_q + (pp_ext << {cnt_q, 1'b0});
`ifdef MBE_PP_CHECK_EN
                if (illegal) begin
                    err_d = 1'b1;
                end
`endif
                if (cnt_q == CW'(N-1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance is shared by IDLE and the back-to-back DONE path; it
        // overrides the DONE->IDLE retirement above.
        if (accept) begin
            y_d     = y;
            sgl_d   = single;
            dbl_d   = double;
            neg_d   = neg;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            sgl_q   <= '0;
            dbl_q   <= '0;
            neg_q   <= '0;
`ifdef MBE_PP_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            sgl_q   <= sgl_d;
            dbl_q   <= dbl_d;
            neg_q   <= neg_d;
`ifdef MBE_PP_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mbe_pp_accum.sv
module tb_mbe_pp_accum;
    import mbe_pkg::*;

    localparam int W = 8;
    localparam int N = 4;
    localparam int P = W + 2 * N;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  y;
    logic [N-1:0]  single;
    logic [N-1:0]  double;
    logic [N-1:0]  neg;
    logic          out_valid;
    logic          out_ready;
    logic [P-1:0]  product;
`ifdef MBE_PP_CHECK_EN
    logic          err;
`endif

    int checks   = 0;
    int failures = 0;

    mbe_pp_accum #(.W(W), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .single   (single),
        .double   (double),
        .neg      (neg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product)
`ifdef MBE_PP_CHECK_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] y;
        logic [N-1:0] sgl;
        logic [N-1:0] dbl;
        logic [N-1:0] ng;
        logic [P-1:0] exp_prod;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; returns edges counted.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic drive(input vec_t v);
        y      = v.y;
        single = v.sgl;
        double = v.dbl;
        neg    = v.ng;
    endtask

    // Scramble inputs after acceptance: the block must ignore them.
    task automatic garble();
        y      = 8'h5A;
        single = 4'b1010;
        double = 4'b0101;
        neg    = 4'b1111;
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        drive(v);
        in_valid = 1'b1;
        chk({v.name, " in_ready before accept"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        garble();
        wait_out(lat);
        chk({v.name, " latency"}, lat, 4);
        chk({v.name, " product"}, int'(product), int'(v.exp_prod));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({v.name, " out_valid after retire"}, int'(out_valid), 0);
        chk({v.name, " in_ready after retire"}, int'(in_ready), 1);
    endtask

    vec_t vecs[6];
    vec_t va, vb, vill;

    initial begin
        int lat;
        logic [P-1:0] held;

        vecs[0] = '{"pos 7x3",       8'd7,    4'b0011, 4'b0000, 4'b0001, 16'h0015};
        vecs[1] = '{"ext -128x-128", 8'h80,   4'b0000, 4'b1000, 4'b1000, 16'h4000};
        vecs[2] = '{"negzero 100x-1",8'd100,  4'b0001, 4'b0000, 4'b1111, 16'hFF9C};
        vecs[3] = '{"-5x6",          8'hFB,   4'b0000, 4'b0011, 4'b0001, 16'hFFE2};
        vecs[4] = '{"127x127",       8'd127,  4'b0001, 4'b1000, 4'b0111, 16'h3F01};
        vecs[5] = '{"0x3",           8'd0,    4'b0011, 4'b0000, 4'b0001, 16'h0000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        y = '0; single = '0; double = '0; neg = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset product", int'(product), 0);
        chk("reset in_ready", int'(in_ready), 1);
`ifdef MBE_PP_CHECK_EN
        chk("reset err", int'(err), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
        end

        // Backpressure then back-to-back acceptance in DONE.
        va = vecs[0];
        vb = vecs[1];
        drive(va);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        garble();
        wait_out(lat);
        chk("b2b first latency", lat, 4);
        held = product;
        chk("b2b first product", int'(held), 16'h0015);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall out_valid", int'(out_valid), 1);
            chk("stall product stable", int'(product), 16'h0015);
            chk("stall in_ready", int'(in_ready), 0);
        end
        drive(vb);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b in_ready comb", int'(in_ready), 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        garble();
        chk("b2b out_valid drops", int'(out_valid), 0);
        wait_out(lat);
        chk("b2b second latency", lat, 4);
        chk("b2b second product", int'(product), 16'h4000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Illegal digit: single&double on digit 0.
        vill = '{"illegal 5", 8'd5, 4'b0001, 4'b0001, 4'b0000, 16'h0000};
`ifndef MBE_PP_CHECK_EN
        vill.exp_prod = 16'h0005;
`endif
        run_op(vill);
`ifdef MBE_PP_CHECK_EN
        chk("err set", int'(err), 1);
        run_op(vecs[0]);
        chk("err sticky", int'(err), 1);
`endif

        // Reset during digit 2: after E1,E2 the block is processing digit 2.
        drive(vecs[4]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrun rst out_valid", int'(out_valid), 0);
        chk("midrun rst product", int'(product), 0);
        chk("midrun rst in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        tick();
        chk("post rst in_ready", int'(in_ready), 1);
`ifdef MBE_PP_CHECK_EN
        chk("post rst err", int'(err), 0);
`endif
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) lat++;
            tick();
        end
        chk("no output after rst", lat, 0);

        run_op(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
